// File: rtl/svm_feat_tx.sv
// Ping-pong frame buffer: collects N_FEAT features, then replays each frame as one unbroken burst followed by GAP idle cycles.
// The first burst beat is registered one cycle after the last feature lands. tready_feat drops only while both banks are full.
module svm_feat_tx #(
  parameter int N_FEAT = 39,
  parameter int DATA_W = 32,
  parameter int GAP    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tvalid_feat,
  input  logic              tfirst_feat,
  input  logic [DATA_W-1:0] feat,
  output logic              tready_feat,
  output logic              tvalid_scaled_feat,
  output logic [DATA_W-1:0] scaled_feat,
  output logic              frame_err,
  output logic [15:0]       frames_sent
);
  localparam int IDX_W = $clog2(N_FEAT);
  localparam int GAP_W = $clog2(GAP + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FEAT - 1);
  localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'(GAP - 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;
  state_t state_q, state_d;

  logic [DATA_W-1:0] mem_q [2][N_FEAT];
  logic [1:0]        full_q, full_d;
  logic              wr_bank_q, wr_bank_d;
  logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
  logic              rd_bank_q, rd_bank_d;
  logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic              out_vld_q, out_vld_d;
  logic [DATA_W-1:0] out_dat_q, out_dat_d;
  logic              frame_err_q, frame_err_d;
  logic [15:0]       frames_sent_q, frames_sent_d;

  logic              wr_fire;
  logic              resync;
  logic [IDX_W-1:0]  wr_addr;

  assign tready_feat = !full_q[wr_bank_q];
  assign wr_fire     = tvalid_feat && tready_feat;
  // A frame start arriving mid-frame abandons the partial frame and restarts at slot 0.
  assign resync      = wr_fire && tfirst_feat && (wr_idx_q != '0);
  assign wr_addr     = resync ? '0 : wr_idx_q;

  assign tvalid_scaled_feat = out_vld_q;
  assign scaled_feat        = out_dat_q;
  assign frame_err          = frame_err_q;
  assign frames_sent        = frames_sent_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      full_q        <= '0;
      wr_bank_q     <= 1'b0;
      wr_idx_q      <= '0;
      rd_bank_q     <= 1'b0;
      rd_idx_q      <= '0;
      gap_cnt_q     <= '0;
      out_vld_q     <= 1'b0;
      out_dat_q     <= '0;
      frame_err_q   <= 1'b0;
      frames_sent_q <= '0;
    end else begin
      state_q       <= state_d;
      full_q        <= full_d;
      wr_bank_q     <= wr_bank_d;
      wr_idx_q      <= wr_idx_d;
      rd_bank_q     <= rd_bank_d;
      rd_idx_q      <= rd_idx_d;
      gap_cnt_q     <= gap_cnt_d;
      out_vld_q     <= out_vld_d;
      out_dat_q     <= out_dat_d;
      frame_err_q   <= frame_err_d;
      frames_sent_q <= frames_sent_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_bank_q][wr_addr] <= feat;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (full_q[rd_bank_q]) state_d = S_SEND;
      S_SEND:  if (rd_idx_q == LAST_IDX) state_d = S_GAP;
      S_GAP:   if (gap_cnt_q == LAST_GAP) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Beat 0 is launched on the IDLE exit edge, so SEND registers beats 1..N_FEAT-1.
  always_comb begin
    full_d        = full_q;
    wr_bank_d     = wr_bank_q;
    wr_idx_d      = wr_idx_q;
    rd_bank_d     = rd_bank_q;
    rd_idx_d      = rd_idx_q;
    gap_cnt_d     = gap_cnt_q;
    out_vld_d     = 1'b0;
    out_dat_d     = '0;
    frame_err_d   = resync;
    frames_sent_d = frames_sent_q;

    unique case (state_q)
      S_IDLE: begin
        if (full_q[rd_bank_q]) begin
          out_vld_d = 1'b1;
          out_dat_d = mem_q[rd_bank_q][0];
          rd_idx_d  = IDX_W'(1);
        end
      end
      S_SEND: begin
        out_vld_d = 1'b1;
        out_dat_d = mem_q[rd_bank_q][rd_idx_q];
        if (rd_idx_q == LAST_IDX) begin
          full_d[rd_bank_q] = 1'b0;
          rd_bank_d         = !rd_bank_q;
          rd_idx_d          = '0;
          gap_cnt_d         = '0;
          frames_sent_d     = frames_sent_q + 16'd1;
        end else begin
          rd_idx_d = rd_idx_q + 1'b1;
        end
      end
      S_GAP:   gap_cnt_d = gap_cnt_q + 1'b1;
      default: ;
    endcase

    if (wr_fire) begin
      if (resync) begin
        wr_idx_d = IDX_W'(1);
      end else if (wr_idx_q == LAST_IDX) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = !wr_bank_q;
        wr_idx_d          = '0;
      end else begin
        wr_idx_d = wr_idx_q + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_svm_feat_tx.sv
// Directed bench for svm_feat_tx: burst framing, ordering, gap spacing, resync, mid-burst reset and counter wrap.
module tb_svm_feat_tx;
  localparam int N     = 39;
  localparam int LIMIT = 2000;

  logic        clk = 1'b0;
  logic        reset;
  logic        tvalid_feat;
  logic        tfirst_feat;
  logic [31:0] feat;
  logic        tready_feat;
  logic        tvalid_scaled_feat;
  logic [31:0] scaled_feat;
  logic        frame_err;
  logic [15:0] frames_sent;

  svm_feat_tx #(.N_FEAT(N), .DATA_W(32), .GAP(8)) dut (
    .clk                (clk),
    .reset              (reset),
    .tvalid_feat        (tvalid_feat),
    .tfirst_feat        (tfirst_feat),
    .feat               (feat),
    .tready_feat        (tready_feat),
    .tvalid_scaled_feat (tvalid_scaled_feat),
    .scaled_feat        (scaled_feat),
    .frame_err          (frame_err),
    .frames_sent        (frames_sent)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Output monitor, sampled 1 time unit after each rising edge.
  logic [31:0] beats[$];
  logic [31:0] exp_q[$];
  int burst_lens[$];
  int gap_lens[$];
  int run = 0, idle_run = 0, err_cnt = 0, nrdy = 0, nz_idle = 0;
  int cyc = 0, first_cyc = -1;
  bit in_burst = 1'b0, seen_burst = 1'b0;
  int clr_seq = 0, clr_seen = 0;

  always @(posedge clk) begin
    #1;
    if (clr_seen != clr_seq) begin
      clr_seen = clr_seq;
      beats.delete();
      burst_lens.delete();
      gap_lens.delete();
      run = 0; idle_run = 0; err_cnt = 0; nrdy = 0; nz_idle = 0;
      in_burst = 1'b0; seen_burst = 1'b0; first_cyc = -1;
    end
    cyc++;
    if (tvalid_scaled_feat) begin
      if (!in_burst && seen_burst) gap_lens.push_back(idle_run);
      if (first_cyc < 0) first_cyc = cyc;
      beats.push_back(scaled_feat);
      run++;
      in_burst = 1'b1;
    end else begin
      if (in_burst) begin
        burst_lens.push_back(run);
        seen_burst = 1'b1;
        idle_run   = 0;
      end
      run      = 0;
      in_burst = 1'b0;
      idle_run++;
      if (scaled_feat !== 32'h0) nz_idle++;
    end
    if (frame_err) err_cnt++;
    if (!tready_feat) nrdy++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_beats(input string tag);
    check({tag, "_count"}, beats.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < beats.size()) check(tag, beats[i], exp_q[i]);
  endtask

  // Called at a falling edge; returns at the falling edge after the beat was accepted.
  task automatic send_beat(input logic [31:0] d, input logic first, input int idle);
    int w;
    tvalid_feat = 1'b1;
    tfirst_feat = first;
    feat        = d;
    w = 0;
    while (!tready_feat && w < LIMIT) begin
      @(negedge clk);
      w++;
    end
    check("tready_wait", (w >= LIMIT), 1'b0);
    @(negedge clk);
    tvalid_feat = 1'b0;
    tfirst_feat = 1'b0;
    feat        = '0;
    repeat (idle) @(negedge clk);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // IEEE-754 single encoding of a small positive integer.
  function automatic logic [31:0] f32_of_int(input int n);
    int e;
    logic [22:0] m;
    e = 0;
    while ((n >> (e + 1)) != 0) e++;
    m = 23'((n - (1 << e)) << (23 - e));
    return {1'b0, 8'(127 + e), m};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_cyc;
    logic [31:0] d;

    reset = 1'b1; tvalid_feat = 1'b0; tfirst_feat = 1'b0; feat = '0;
    repeat (3) @(negedge clk);
    check("rst_tready", tready_feat, 1'b1);
    check("rst_tvalid", tvalid_scaled_feat, 1'b0);
    check("rst_data", scaled_feat, 32'h0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_frames_sent", frames_sent, 16'h0);
    reset = 1'b0;
    @(negedge clk);

    // Single frame of 1.0..39.0 with random gaps.
    clr_seq++;
    exp_q.delete();
    for (int i = 0; i < N; i++) begin
      exp_q.push_back(f32_of_int(i + 1));
      send_beat(f32_of_int(i + 1), (i == 0), (i == N - 1) ? 0 : int'($urandom_range(0, 3)));
    end
    acc_cyc = cyc;
    wait_cycles(N + 12);
    check("t1_latency", first_cyc, acc_cyc + 1);
    check("t1_bursts", burst_lens.size(), 1);
    if (burst_lens.size() > 0) check("t1_burst_len", burst_lens[0], N);
    check_beats("t1_beat");
    if (beats.size() == N) begin
      check("t1_first_1p0", beats[0], 32'h3F80_0000);
      check("t1_last_39p0", beats[N - 1], 32'h421C_0000);
    end
    check("t1_trailing_idle", (idle_run >= 8), 1'b1);
    check("t1_idle_zero", nz_idle, 0);
    check("t1_frames_sent", frames_sent, 16'd1);

    // Three frames back to back.
    clr_seq++;
    exp_q.delete();
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < N; i++) begin
        d = 32'(32'hF000_0000 + f * 256 + i);
        exp_q.push_back(d);
        send_beat(d, (i == 0), 0);
      end
    wait_cycles(80);
    check("t2_bursts", burst_lens.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < burst_lens.size()) check("t2_burst_len", burst_lens[i], N);
    check("t2_gaps", gap_lens.size(), 2);
    for (int i = 0; i < 2; i++)
      if (i < gap_lens.size()) check("t2_gap_len", gap_lens[i], 8);
    check_beats("t2_beat");
    check("t2_not_ready_cycles", nrdy, 8);
    check("t2_idle_zero", nz_idle, 0);
    check("t2_frames_sent", frames_sent, 16'd4);

    // Truncated frame A, then frame B with a fresh tfirst.
    clr_seq++;
    exp_q.delete();
    for (int i = 0; i < 20; i++) send_beat(32'hA000_0000 + 32'(i), (i == 0), 0);
    for (int i = 0; i < N; i++) begin
      d = 32'hB000_0000 + 32'(i);
      exp_q.push_back(d);
      send_beat(d, (i == 0), 0);
    end
    wait_cycles(60);
    check("t3_frame_err_pulses", err_cnt, 1);
    check("t3_bursts", burst_lens.size(), 1);
    check_beats("t3_beat");
    check("t3_frames_sent", frames_sent, 16'd5);

    // Reset during beat 10 of a burst.
    clr_seq++;
    for (int i = 0; i < N; i++) send_beat(32'hC000_0000 + 32'(i), (i == 0), 0);
    wait_cycles(10);
    reset = 1'b1;
    @(negedge clk);
    check("t4_beats_before_reset", beats.size(), 10);
    check("t4_tvalid", tvalid_scaled_feat, 1'b0);
    check("t4_data", scaled_feat, 32'h0);
    check("t4_tready", tready_feat, 1'b1);
    check("t4_frame_err", frame_err, 1'b0);
    check("t4_frames_sent", frames_sent, 16'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    clr_seq++;
    exp_q.delete();
    for (int i = 0; i < N; i++) begin
      d = 32'hD000_0000 + 32'(i);
      exp_q.push_back(d);
      send_beat(d, (i == 0), 0);
    end
    wait_cycles(55);
    check("t4_fresh_bursts", burst_lens.size(), 1);
    check_beats("t4_fresh_beat");
    check("t4_fresh_frames_sent", frames_sent, 16'd1);

    // Counter wrap from 0xFFFF.
    force dut.frames_sent_q = 16'hFFFF;
    @(negedge clk);
    release dut.frames_sent_q;
    check("t5_preset", frames_sent, 16'hFFFF);
    clr_seq++;
    exp_q.delete();
    for (int i = 0; i < N; i++) begin
      d = 32'hE000_0000 + 32'(i);
      exp_q.push_back(d);
      send_beat(d, (i == 0), 0);
    end
    wait_cycles(55);
    check("t5_wrap", frames_sent, 16'h0);
    check_beats("t5_beat");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
